// File: rtl/pwm_bank.sv
// Bank of independent PWM channels with per-channel shadow duty, wrap-aligned updates
// and enable gating. Optional duty ramping is compiled in with `define PWM_BANK_RAMP_EN.
module pwm_bank #(
  parameter int CHANNELS  = 4,
  parameter int SIZE      = 21,
  parameter int PERIOD    = 2000000,
  parameter int STAGGER   = 0,
  parameter int RAMP_STEP = 1000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CHANNELS*SIZE-1:0] width,
  input  logic [CHANNELS-1:0]      load,
  input  logic [CHANNELS-1:0]      enable,
  output logic [CHANNELS-1:0]      pwm,
  output logic [CHANNELS-1:0]      period_finished,
  output logic [CHANNELS-1:0]      ramping
);

`ifdef PWM_BANK_RAMP_EN
  localparam bit RAMP_EN = 1'b1;
`else
  localparam bit RAMP_EN = 1'b0;
`endif

  localparam logic [SIZE-1:0] PERIOD_V = SIZE'(PERIOD);
  localparam logic [SIZE-1:0] LAST_V   = SIZE'(PERIOD - 1);
  // Without ramping the step limit is unbounded, so active jumps straight to the target.
  localparam logic [SIZE-1:0] STEP_LIM =
    !RAMP_EN ? '1 : ((RAMP_STEP >= (2 ** SIZE)) ? '1 : SIZE'(RAMP_STEP));

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    localparam logic [SIZE-1:0] START = (STAGGER != 0) ? SIZE'(g * (PERIOD / CHANNELS)) : '0;

    logic [SIZE-1:0] cnt_q, cnt_d;
    logic [SIZE-1:0] shadow_q, shadow_d;
    logic [SIZE-1:0] active_q, active_d;
    logic [SIZE-1:0] req, diff;
    logic            run_q, run_d;
    logic            pwm_q, pwm_d;
    logic            pf_q, pf_d;
    logic            wrap;

    always_comb begin
      req = width[g*SIZE +: SIZE];
      if (req > PERIOD_V) req = PERIOD_V;

      wrap  = (cnt_q == LAST_V);
      cnt_d = wrap ? '0 : cnt_q + SIZE'(1);
      pf_d  = wrap;

      // A load landing on the wrap cycle is already visible as the new target here.
      shadow_d = load[g] ? req : shadow_q;

      diff     = '0;
      active_d = active_q;
      if (wrap) begin
        if (shadow_d > active_q) begin
          diff     = shadow_d - active_q;
          active_d = active_q + ((diff > STEP_LIM) ? STEP_LIM : diff);
        end else begin
          diff     = active_q - shadow_d;
          active_d = active_q - ((diff > STEP_LIM) ? STEP_LIM : diff);
        end
      end

      // Disable takes effect immediately; re-enable waits for a period boundary.
      run_d = enable[g] ? (run_q | wrap) : 1'b0;
      pwm_d = run_q & enable[g] & (cnt_q < active_q);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q    <= START;
        shadow_q <= '0;
        active_q <= '0;
        run_q    <= 1'b0;
        pwm_q    <= 1'b0;
        pf_q     <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        shadow_q <= shadow_d;
        active_q <= active_d;
        run_q    <= run_d;
        pwm_q    <= pwm_d;
        pf_q     <= pf_d;
      end
    end

    assign pwm[g]             = pwm_q;
    assign period_finished[g] = pf_q;
    assign ramping[g]         = RAMP_EN ? (active_q != shadow_q) : 1'b0;
  end

endmodule
